// File: rtl/dump_pkg.sv
// dump_pkg: shared types and sizing helpers for the end-of-run result dumper.
`default_nettype none

package dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_WORDS  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // pc plus the three prediction counters precede the register file
  localparam int FIXED_WORDS = 4;

  function automatic int word_count(input int num_regs);
    return FIXED_WORDS + num_regs;
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_dumper.sv
// result_dumper: on a rising edge of completed, snapshots pc/preds/regs and
// streams them as a header byte plus little-endian words over a valid/ready link.
`default_nettype none

module result_dumper
  import dump_pkg::*;
#(
  parameter logic [7:0] HEADER   = DEFAULT_HEADER,
  parameter int         NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        completed,
  input  logic [31:0] pc,
  input  logic [31:0] preds [3],
  input  logic [31:0] regs  [NUM_REGS],
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int NWORDS = word_count(NUM_REGS);
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic              completed_q;
  logic [WIDX_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [31:0]       snap [NWORDS];
  logic              trigger;
  logic              handshake;
  logic              last_byte;

  assign trigger   = completed & ~completed_q;
  assign handshake = tx_valid & tx_ready;
  assign last_byte = (word_idx == LAST_WORD) && (byte_idx == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      completed_q <= 1'b0;
    end else begin
      completed_q <= completed;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (trigger) state_nxt = ST_HEADER;
      ST_HEADER: if (handshake) state_nxt = ST_WORDS;
      ST_WORDS:  if (handshake && last_byte) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Counters hold on the final byte so they never wrap inside a frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_idx <= '0;
      byte_idx <= 2'd0;
    end else if (state == ST_IDLE) begin
      word_idx <= '0;
      byte_idx <= 2'd0;
    end else if (state == ST_WORDS && handshake && !last_byte) begin
      if (byte_idx == 2'd3) begin
        byte_idx <= 2'd0;
        word_idx <= word_idx + WIDX_W'(1);
      end else begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  // Snapshot is captured only when leaving IDLE, so later triggers cannot disturb it.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && trigger) begin
      snap[0] <= pc;
      snap[1] <= preds[0];
      snap[2] <= preds[1];
      snap[3] <= preds[2];
      for (int i = 0; i < NUM_REGS; i++) begin
        snap[FIXED_WORDS + i] <= regs[i];
      end
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    tx_data  = 8'h00;
    case (state)
      ST_HEADER: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = HEADER;
      end
      ST_WORDS: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = snap[word_idx][{byte_idx, 3'b000} +: 8];
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        tx_data = 8'h00;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_result_dumper.sv
// tb_result_dumper: directed scenarios with randomized data/backpressure,
// checked against a byte-queue frame model built from the input values.
`default_nettype none

module tb_result_dumper;

  localparam int NUM_REGS = 32;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        completed;
  logic [31:0] pc;
  logic [31:0] preds [3];
  logic [31:0] regs  [NUM_REGS];
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q [$];

  result_dumper #(.HEADER(HDR), .NUM_REGS(NUM_REGS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .completed (completed),
    .pc        (pc),
    .preds     (preds),
    .regs      (regs),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Expected frame: header, then every word split into bytes, low byte first.
  task automatic build_expected();
    logic [31:0] words [$];
    exp_q.delete();
    words.push_back(pc);
    for (int k = 0; k < 3; k++) words.push_back(preds[k]);
    for (int k = 0; k < NUM_REGS; k++) words.push_back(regs[k]);
    exp_q.push_back(HDR);
    foreach (words[w]) begin
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((words[w] >> (8 * b)) & 32'hFF));
    end
  endtask

  task automatic load_basic();
    pc = 32'h0000_0123;
    preds[0] = 32'd10;
    preds[1] = 32'd7;
    preds[2] = 32'd3;
    for (int k = 0; k < NUM_REGS; k++) regs[k] = k;
  endtask

  task automatic load_random();
    pc = $urandom;
    for (int k = 0; k < 3; k++) preds[k] = $urandom;
    for (int k = 0; k < NUM_REGS; k++) regs[k] = $urandom;
  endtask

  // mode 0: ready always high; 1: pattern 1,0,0,1; 2: random ready
  task automatic run_frame(input int mode, input int stop_after, input bit mutate,
                           input bit retrig, output int got, output int cycles);
    int idx = 0;
    int cyc = 0;
    int target;
    bit stalled = 0;
    logic [7:0] held = 8'h00;
    target = (stop_after < 0) ? exp_q.size() : stop_after;
    while (idx < target && cyc < 2000) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      check("valid_in_frame", {31'd0, tx_valid}, 32'd1);
      check("busy_eq_valid", {31'd0, busy}, {31'd0, tx_valid});
      if (stalled) check("stall_data", {24'd0, tx_data}, {24'd0, held});
      if (tx_valid && tx_ready) begin
        check("byte", {24'd0, tx_data}, {24'd0, exp_q[idx]});
        idx++;
        stalled = 0;
      end else begin
        stalled = 1;
        held = tx_data;
      end
      if (mutate && idx == 20) regs[5] = 32'hDEAD_BEEF;
      if (retrig && idx == 30) completed = 1'b0;
      if (retrig && idx == 40) completed = 1'b1;
      cyc++;
      tick();
    end
    check("frame_bytes", idx, target);
    got = idx;
    cycles = cyc;
  endtask

  initial begin
    int got;
    int cyc;

    rstn = 1'b0;
    completed = 1'b0;
    tx_ready = 1'b0;
    pc = '0;
    for (int k = 0; k < 3; k++) preds[k] = '0;
    for (int k = 0; k < NUM_REGS; k++) regs[k] = '0;
    repeat (3) tick();

    // Reset state, with tx_ready high too
    tx_ready = 1'b1;
    tick();
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);

    // Idle with ready high and no trigger must stay quiet
    rstn = 1'b1;
    repeat (3) tick();
    check("idle_valid", {31'd0, tx_valid}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);

    // Basic frame, ready held high, with mid-frame data change and retrigger
    load_basic();
    build_expected();
    completed = 1'b1;
    tick();
    check("lat_valid", {31'd0, tx_valid}, 32'd1);
    check("lat_hdr", {24'd0, tx_data}, 32'hA5);
    run_frame(0, -1, 1'b1, 1'b1, got, cyc);
    check("basic_len", got, 145);
    check("no_bubbles", cyc, 145);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_valid_off", {31'd0, tx_valid}, 32'd0);

    // Retrigger after DONE is ignored
    completed = 1'b0;
    tick();
    completed = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_done_valid", {31'd0, tx_valid}, 32'd0);
      check("post_done_sticky", {31'd0, done}, 32'd1);
    end

    // Completed already high at reset release, backpressure 1,0,0,1
    rstn = 1'b0;
    #1;
    check("async_rst_done", {31'd0, done}, 32'd0);
    load_basic();
    build_expected();
    tick();
    rstn = 1'b1;
    check("rel_cycle1_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    check("rel_cycle2_valid", {31'd0, tx_valid}, 32'd1);
    check("rel_cycle2_hdr", {24'd0, tx_data}, 32'hA5);
    run_frame(1, -1, 1'b1, 1'b0, got, cyc);
    check("bp_len", got, 145);
    check("bp_done", {31'd0, done}, 32'd1);

    // Random data and ready, aborted by reset after byte 40
    rstn = 1'b0;
    completed = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    load_random();
    build_expected();
    completed = 1'b1;
    tick();
    check("r1_hdr", {24'd0, tx_data}, 32'hA5);
    run_frame(2, 40, 1'b0, 1'b0, got, cyc);
    rstn = 1'b0;
    #1;
    check("abort_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data", {24'd0, tx_data}, 32'd0);
    tick();
    rstn = 1'b1;
    completed = 1'b0;
    tick();
    check("after_abort_idle", {31'd0, tx_valid}, 32'd0);

    // Fresh full frame after the abort
    load_random();
    build_expected();
    completed = 1'b1;
    tick();
    check("r2_hdr", {24'd0, tx_data}, 32'hA5);
    run_frame(2, -1, 1'b0, 1'b0, got, cyc);
    check("r2_len", got, 145);
    check("r2_done", {31'd0, done}, 32'd1);
    check("r2_valid_off", {31'd0, tx_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_dumper.md
RESULT_DUMPER -- requirements
Module: result_dumper

Interface
REQ-001 The module SHALL have parameter HEADER, default 8'hA5, meaning the frame start byte.
REQ-002 The module SHALL have parameter NUM_REGS, default 32, meaning the number of register-file words dumped.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The module SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port completed, input, 1 bit: level from core, high once the program has finished.
REQ-006 The module SHALL have port pc, input, 32 bits: final program counter from core.
REQ-007 The module SHALL have port preds, input, 3x32 bits: prediction counters {total, succeed, fail} from core.
REQ-008 The module SHALL have port regs, input, NUM_REGSx32 bits: architectural register file from core.
REQ-009 The module SHALL have port tx_data, output, 8 bits: byte offered to the downstream serializer.
REQ-010 The module SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-011 The module SHALL have port tx_ready, input, 1 bit: downstream accepts the byte this cycle.
REQ-012 The module SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 The module SHALL have port done, output, 1 bit: sticky, frame fully sent.

Function
REQ-014 A trigger SHALL be a rising edge of completed, detected with a registered copy of completed that resets to 0.
REQ-015 On the trigger clock edge, the module SHALL snapshot pc, preds[0..2] and regs[0..NUM_REGS-1] into internal storage, giving 4+NUM_REGS words.
REQ-016 Later changes on pc, preds or regs SHALL NOT affect the frame being sent.
REQ-017 Frame order SHALL be: HEADER, pc, preds[0], preds[1], preds[2], regs[0] .. regs[NUM_REGS-1].
REQ-018 Each word SHALL be sent little-endian (bits 7:0 first), giving 1+4*(4+NUM_REGS) bytes; this is 145 bytes at the default.
REQ-019 The state machine SHALL have states IDLE, HEADER, WORDS and DONE.
REQ-020 IDLE SHALL go to HEADER on a trigger.
REQ-021 HEADER SHALL go to WORDS on handshake.
REQ-022 WORDS SHALL advance the byte index 0..3, then the word index; after the handshake of the last byte of the last word it SHALL go to DONE.
REQ-023 DONE SHALL be terminal until reset.
REQ-024 The first tx_valid SHALL appear in the cycle after the trigger edge; the latency is 1 cycle.
REQ-025 A handshake SHALL be tx_valid and tx_ready both high at a clock edge.
REQ-026 tx_data SHALL be held stable while tx_valid is high and tx_ready is low.
REQ-027 tx_valid SHALL NOT drop without a handshake.
REQ-028 With tx_ready held high, one byte SHALL transfer per cycle with no bubbles.
REQ-029 tx_valid SHALL be high exactly in states HEADER and WORDS.
REQ-030 busy SHALL equal tx_valid.
REQ-031 done SHALL be high exactly in state DONE, asserted the cycle after the final handshake.
REQ-032 Triggers in HEADER, WORDS or DONE SHALL be ignored, and the snapshot SHALL NOT be overwritten.
REQ-033 If completed is already high in the first cycle after reset release, that SHALL count as a trigger.
REQ-034 If tx_ready is high while tx_valid is low, the module SHALL ignore it.
REQ-035 Word and byte counters SHALL be sized for 4+NUM_REGS words and SHALL NOT wrap within a frame.

Reset
REQ-036 While rstn is low: state is IDLE; tx_valid, busy and done are 0; tx_data is 8'h00; counters and the completed copy are 0.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately, with no further bytes.
REQ-038 After reset release, a new trigger SHALL send a complete fresh frame.
REQ-039 Snapshot storage does not need reset.

Structure
REQ-040 Package dump_pkg SHALL hold the state enum, the default HEADER value, and the function computing the word count (4+NUM_REGS).
REQ-041 A single module SHALL be used with no sub-modules; the downstream UART transmitter is a separate block connected through tx_*.

Verification
REQ-042 Scenario, basic frame: pc=0x0000_0123, preds={10,7,3}, regs[i]=i, tx_ready=1, completed 0->1. Required: 145 consecutive valid bytes A5,23,01,00,00,0A,00,00,00,07,...; the final bytes are 1F,00,00,00; done rises the next cycle.
REQ-043 Scenario, backpressure: tx_ready toggling 1,0,0,1 repeating. Required: tx_data is stable across every stall, byte sequence identical to REQ-042, no drops or duplicates.
REQ-044 Scenario, snapshot isolation: after the trigger, change regs[5] to 0xDEADBEEF mid-frame. Required: the frame still carries 05,00,00,00 for regs[5].
REQ-045 Scenario, retrigger: pulse completed 0->1->0->1 during WORDS and after DONE. Required: exactly one frame; done stays 1.
REQ-046 Scenario, reset mid-frame: assert rstn=0 after byte 40. Required: tx_valid=0 and done=0 at once; after release plus a new trigger, a full 145-byte frame starting with A5.
REQ-047 Scenario, completed high at reset release. Required: A5 is offered in the second cycle after release.
